// File: rtl/framebuffer_plot_sink_pkg.sv
// Shared types and screen geometry for the plot sink: 160x120 framebuffer, 3-bit colour.
package fb_pkg;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_PIXELS = SCREEN_W * SCREEN_H;
  localparam int FB_AW     = 15;
  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_PIXELS - 1);

  typedef logic [2:0] colour_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    colour_t    colour;
  } plot_t;

  localparam int PLOT_W = $bits(plot_t);

  typedef enum logic {IDLE, CLEAR} fsm_t;

  // y*160 + x as shifts: y*128 + y*32 + x
  function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] px, input logic [6:0] py);
    return ({8'd0, py} << 7) + ({8'd0, py} << 5) + {7'd0, px};
  endfunction
endpackage

// File: rtl/framebuffer_plot_sink_fifo.sv
// Synchronous plot FIFO; full/empty derived from registered wrap-bit pointers.
module plot_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [PLOT_W-1:0] din,
  output logic [PLOT_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PLOT_W-1:0] mem [DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;

  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/framebuffer_plot_sink.sv
// Plot stream sink: FIFO -> framebuffer RAM, bulk clear engine, 1-cycle readback.
// Optional FRAME_CHECKSUM_EN adds frame_checksum (sum of committed colours per frame).
//   state | meaning
//   IDLE  | drain one FIFO entry per cycle into the RAM
//   CLEAR | fill all 19200 pixels with the captured colour, FIFO held
module framebuffer_plot_sink
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  output logic        ready,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic        busy,
  input  logic        rd_req,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic        rd_valid,
  output logic [2:0]  rd_colour,
  output logic        frame_done,
  output logic [7:0]  drop_count
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0] frame_checksum
`endif
);
  fsm_t              state;
  colour_t           clr_colour;
  logic [FB_AW-1:0]  clr_addr;
  logic              full, empty, push, pop, in_range, rd_in_range;
  logic [PLOT_W-1:0] fifo_dout;
  plot_t             head;
  logic [FB_AW-1:0]  pop_addr, wr_addr, rd_addr;
  logic              wr_en;
  colour_t           wr_data;
  colour_t           mem [FB_PIXELS];

  assign in_range    = (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
  assign rd_in_range = (rd_x < 8'(SCREEN_W)) && (rd_y < 7'(SCREEN_H));
  assign ready       = !full;
  assign push        = plot && ready && in_range;
  assign pop         = (state == IDLE) && !clear_req && !empty;
  assign head        = plot_t'(fifo_dout);
  assign pop_addr    = fb_addr(head.x, head.y);
  assign rd_addr     = fb_addr(rd_x, rd_y);

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      ({x, y, colour}),
    .dout     (fifo_dout),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    wr_en   = pop;
    wr_addr = pop_addr;
    wr_data = head.colour;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = clr_colour;
    end
  end

  // RAM contents deliberately survive reset
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read sees pre-write contents when addresses collide
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_colour <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_colour <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      clr_addr   <= '0;
      clr_colour <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && (pop_addr == FB_LAST);
      case (state)
        IDLE: if (clear_req) begin
          state      <= CLEAR;
          busy       <= 1'b1;
          clr_addr   <= '0;
          clr_colour <= clear_colour;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == FB_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) drop_count <= '0;
    else if (plot && ready && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] csum_acc;
  logic [15:0] csum_next;
  assign csum_next = csum_acc + 16'(head.colour);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      csum_acc       <= '0;
      frame_checksum <= '0;
    end else if (pop) begin
      if (pop_addr == FB_LAST) begin
        frame_checksum <= csum_next;
        csum_acc       <= '0;
      end else begin
        csum_acc <= csum_next;
      end
    end
  end
`endif
endmodule

// File: tb/tb_framebuffer_plot_sink.sv
// Randomised self-checking bench for framebuffer_plot_sink against a pixel-array reference model.
module tb_framebuffer_plot_sink;
  logic        CLOCK_50 = 1'b0;
  logic        reset, plot, clear_req, rd_req;
  logic [7:0]  x, rd_x;
  logic [6:0]  y, rd_y;
  logic [2:0]  colour, clear_colour;
  logic        ready, busy, rd_valid, frame_done;
  logic [2:0]  rd_colour;
  logic [7:0]  drop_count;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0] frame_checksum;
`endif

  framebuffer_plot_sink #(.FIFO_DEPTH(4)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .ready        (ready),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .busy         (busy),
    .rd_req       (rd_req),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_valid     (rd_valid),
    .rd_colour    (rd_colour),
    .frame_done   (frame_done),
    .drop_count   (drop_count)
`ifdef FRAME_CHECKSUM_EN
    ,
    .frame_checksum (frame_checksum)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  logic [2:0] ref_fb [19200];
  int ref_drop;
  int sweep_val;

  always @(negedge CLOCK_50) if (frame_done === 1'b1) fd_count++;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; plot = 1'b0; clear_req = 1'b0; rd_req = 1'b0;
    step(); step();
    reset = 1'b0;
    ref_drop = 0;
  endtask

  task automatic send_plot(input int px, input int py, input logic [2:0] pc);
    plot = 1'b1; x = px[7:0]; y = py[6:0]; colour = pc;
    for (int i = 0; i < 100 && !ready; i++) step();
    if (!ready) begin
      checks++; errors++;
      $display("FAIL send_plot_ready got %0b expected 1", ready);
    end
    step();
    plot = 1'b0;
  endtask

  task automatic rd_pixel(input int px, input int py, output logic v, output logic [2:0] c);
    rd_req = 1'b1; rd_x = px[7:0]; rd_y = py[6:0];
    step();
    rd_req = 1'b0;
    v = rd_valid; c = rd_colour;
  endtask

  // Reference model: a committed in-range plot overwrites its pixel; out-of-range ones count drops
  task automatic model_plot(input int px, input int py, input logic [2:0] pc, inout int fd_exp);
    if (px < 160 && py < 120) begin
      ref_fb[py * 160 + px] = pc;
      if (px == 159 && py == 119) fd_exp++;
    end else if (ref_drop < 255) begin
      ref_drop++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; plot = 1'b0; clear_req = 1'b0; rd_req = 1'b0;
    x = '0; y = '0; colour = '0; clear_colour = '0; rd_x = '0; rd_y = '0;
    step(); step(); step();
    checks++;
    if ({ready, busy, rd_valid, rd_colour, frame_done, drop_count} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b busy=%b rv=%b rc=%0d fd=%b drop=%0d expected 1 0 0 0 0 0",
               ready, busy, rd_valid, rd_colour, frame_done, drop_count);
    end
    reset = 1'b0;
    ref_drop = 0;
  endtask

  task automatic test_single_plot();
    logic v; logic [2:0] c;
    send_plot(5, 3, 3'd6);
    rd_pixel(5, 3, v, c);
    rd_pixel(5, 3, v, c);
    checks++;
    if ({v, c} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL plot_latency got v=%b c=%0d expected v=1 c=6", v, c);
    end
    send_plot(5, 3, 3'd1);
    rd_pixel(5, 3, v, c);
    checks++;
    if (c !== 3'd6) begin
      errors++; $display("FAIL read_during_write got %0d expected 6", c);
    end
    rd_pixel(5, 3, v, c);
    checks++;
    if (c !== 3'd1) begin
      errors++; $display("FAIL overwrite got %0d expected 1", c);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_valid_drop got %b expected 0", rd_valid);
    end
    rd_pixel(200, 5, v, c);
    checks++;
    if ({v, c} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL rd_oob_x got v=%b c=%0d expected v=1 c=0", v, c);
    end
    rd_pixel(5, 3, v, c);
    rd_pixel(10, 125, v, c);
    checks++;
    if ({v, c} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL rd_oob_y got v=%b c=%0d expected v=1 c=0", v, c);
    end
  endtask

  task automatic test_clear_block();
    int ex[5]; int ey[5]; logic [2:0] ec[5];
    int k, busy_cycles, idx, fd0, dummy;
    logic done, ready_late, v;
    logic [2:0] c;
    for (int i = 0; i < 5; i++) begin
      ex[i] = $urandom_range(0, 158);
      ey[i] = $urandom_range(i * 24, i * 24 + 20);
      ec[i] = 3'($urandom_range(0, 7));
    end
    ex[3] = ex[1]; ey[3] = ey[1]; ec[3] = ec[1] ^ 3'd5;
    fd0 = fd_count;
    clear_req = 1'b1; clear_colour = 3'd2;
    plot = 1'b1; x = ex[0][7:0]; y = ey[0][6:0]; colour = ec[0];
    k = ready ? 1 : 0;
    step();
    clear_req = 1'b0;
    busy_cycles = 0; done = 1'b0; ready_late = 1'b1;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (cyc < 8) begin
        idx = (k < 4) ? k : 4;
        plot = 1'b1; x = ex[idx][7:0]; y = ey[idx][6:0]; colour = ec[idx];
      end else begin
        plot = 1'b0;
      end
      if (busy) begin
        busy_cycles++;
        if (cyc < 8 && ready) k++;
        if (cyc == 7) ready_late = ready;
        step();
      end else begin
        done = 1'b1;
      end
    end
    plot = 1'b0;
    repeat (8) step();
    checks++;
    if (busy_cycles != 19200) begin
      errors++; $display("FAIL clear_busy_cycles got %0d expected 19200", busy_cycles);
    end
    checks++;
    if (k != 4) begin
      errors++; $display("FAIL fifo_accept_count got %0d expected 4", k);
    end
    checks++;
    if (ready_late !== 1'b0) begin
      errors++; $display("FAIL fifo_full_ready got %b expected 0", ready_late);
    end
    for (int a = 0; a < 19200; a++) ref_fb[a] = 3'd2;
    dummy = 0;
    for (int i = 0; i < 4; i++) model_plot(ex[i], ey[i], ec[i], dummy);
    for (int i = 0; i < 5; i++) begin
      rd_pixel(ex[i], ey[i], v, c);
      checks++;
      if (c !== ref_fb[ey[i] * 160 + ex[i]]) begin
        errors++; $display("FAIL fifo_order_px%0d got %0d expected %0d", i, c, ref_fb[ey[i] * 160 + ex[i]]);
      end
    end
    rd_pixel(159, 119, v, c);
    checks++;
    if (c !== 3'd2) begin
      errors++; $display("FAIL clear_last_pixel got %0d expected 2", c);
    end
    checks++;
    if (fd_count != fd0) begin
      errors++; $display("FAIL clear_no_frame_done got %0d pulses expected 0", fd_count - fd0);
    end
  endtask

  task automatic test_drops();
    logic v; logic [2:0] c;
    int dummy;
    do_reset();
    dummy = 0;
    send_plot(160, 0, 3'd7); model_plot(160, 0, 3'd7, dummy);
    send_plot(0, 120, 3'd7); model_plot(0, 120, 3'd7, dummy);
    step();
    checks++;
    if (drop_count !== 8'(ref_drop)) begin
      errors++; $display("FAIL drop_two got %0d expected %0d", drop_count, ref_drop);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL drop_ready got %b expected 1", ready);
    end
    rd_pixel(0, 1, v, c);
    checks++;
    if (c !== ref_fb[160]) begin
      errors++; $display("FAIL drop_ram_unchanged got %0d expected %0d", c, ref_fb[160]);
    end
    for (int i = 0; i < 300; i++) begin
      int bx, by;
      if ($urandom_range(0, 1) == 1) begin
        bx = $urandom_range(160, 255); by = $urandom_range(0, 127);
      end else begin
        bx = $urandom_range(0, 255); by = $urandom_range(120, 127);
      end
      send_plot(bx, by, 3'($urandom_range(0, 7)));
      model_plot(bx, by, 3'd0, dummy);
    end
    checks++;
    if (drop_count !== 8'(ref_drop)) begin
      errors++; $display("FAIL drop_saturate got %0d expected %0d", drop_count, ref_drop);
    end
  endtask

  task automatic test_random();
    int touched[$];
    int fd_exp, fd0, px, py, r;
    logic [2:0] pc, c;
    logic v;
    do_reset();
    fd0 = fd_count; fd_exp = 0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        px = $urandom_range(0, 255); py = $urandom_range(120, 127);
      end else if (r < 18) begin
        px = 159; py = 119;
      end else begin
        px = $urandom_range(0, 159); py = $urandom_range(0, 119);
      end
      pc = 3'($urandom_range(0, 7));
      send_plot(px, py, pc);
      model_plot(px, py, pc, fd_exp);
      if (px < 160 && py < 120) touched.push_back(py * 160 + px);
      if ($urandom_range(0, 3) == 0) step();
    end
    repeat (6) step();
    checks++;
    if (drop_count !== 8'(ref_drop)) begin
      errors++; $display("FAIL random_drops got %0d expected %0d", drop_count, ref_drop);
    end
    checks++;
    if (fd_count - fd0 != fd_exp) begin
      errors++; $display("FAIL random_frame_done got %0d expected %0d", fd_count - fd0, fd_exp);
    end
    foreach (touched[i]) begin
      rd_pixel(touched[i] % 160, touched[i] / 160, v, c);
      checks++;
      if ({v, c} !== {1'b1, ref_fb[touched[i]]}) begin
        errors++; $display("FAIL random_pixel addr=%0d got v=%b c=%0d expected v=1 c=%0d", touched[i], v, c, ref_fb[touched[i]]);
      end
    end
  endtask

  task automatic test_raster_sweep();
    int fd0, sum, dummy;
    do_reset();
    fd0 = fd_count; sum = 0; dummy = 0;
    for (int py = 0; py < 120; py++) begin
      for (int px = 0; px < 160; px++) begin
        send_plot(px, py, 3'((px ^ py) & 7));
        model_plot(px, py, 3'((px ^ py) & 7), dummy);
        sum += (px ^ py) & 7;
      end
    end
    repeat (4) step();
    checks++;
    if (fd_count - fd0 != 1) begin
      errors++; $display("FAIL sweep_frame_done got %0d pulses expected 1", fd_count - fd0);
    end
`ifdef FRAME_CHECKSUM_EN
    checks++;
    if (frame_checksum !== 16'(sum)) begin
      errors++; $display("FAIL sweep_checksum got %0d expected %0d", frame_checksum, sum % 65536);
    end
`endif
    for (int a = 0; a < 19200; a++) begin
      rd_req = 1'b1; rd_x = 8'(a % 160); rd_y = 7'(a / 160);
      step();
      checks++;
      if ({rd_valid, rd_colour} !== {1'b1, ref_fb[a]}) begin
        errors++; $display("FAIL sweep_readback addr=%0d got v=%b c=%0d expected v=1 c=%0d", a, rd_valid, rd_colour, ref_fb[a]);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    logic v; logic [2:0] c, pc;
    sweep_val = (80 ^ 100) & 7;
    pc = 3'(sweep_val) ^ 3'd1;
    clear_req = 1'b1; clear_colour = 3'd5;
    step();
    clear_req = 1'b0;
    for (int cyc = 0; cyc < 999; cyc++) begin
      if (cyc == 10) begin plot = 1'b1; x = 8'd80; y = 7'd100; colour = pc; end
      if (cyc == 11) plot = 1'b0;
      step();
    end
    reset = 1'b1;
    step();
    checks++;
    if ({busy, ready} !== 2'b01) begin
      errors++; $display("FAIL reset_mid_clear got busy=%b ready=%b expected busy=0 ready=1", busy, ready);
    end
    reset = 1'b0;
    repeat (6) step();
    rd_pixel(80, 100, v, c);
    checks++;
    if (c !== ref_fb[100 * 160 + 80]) begin
      errors++; $display("FAIL fifo_flushed got %0d expected %0d", c, ref_fb[100 * 160 + 80]);
    end
    rd_pixel(0, 0, v, c);
    checks++;
    if (c !== 3'd5) begin
      errors++; $display("FAIL partial_clear_start got %0d expected 5", c);
    end
    rd_pixel(40, 31, v, c);
    checks++;
    if (c !== ref_fb[31 * 160 + 40]) begin
      errors++; $display("FAIL clear_abandoned got %0d expected %0d", c, ref_fb[31 * 160 + 40]);
    end
    send_plot(7, 7, pc);
    step(); step();
    rd_pixel(7, 7, v, c);
    checks++;
    if (c !== pc) begin
      errors++; $display("FAIL post_reset_plot got %0d expected %0d", c, pc);
    end
  endtask

  initial begin
    test_reset();
    test_single_plot();
    test_clear_block();
    test_drops();
    test_random();
    test_raster_sweep();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
